// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control sequencer for a MIPS datapath with one shared
// instruction/data memory port using a req/ready handshake.
module mips_multicycle_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  opcode,
   input  logic [5:0]  funct,
   input  logic        zero,
   input  logic        mem_ready,
   output logic        mem_req,
   output logic        mem_we,
   output logic        iord,
   output logic        ir_write,
   output logic        pc_write,
   output logic [1:0]  pc_src,
   output logic        alu_src_a,
   output logic [1:0]  alu_src_b,
   output logic [2:0]  alu_ctrl,
   output logic        reg_write,
   output logic        reg_dst,
   output logic        mem_to_reg,
   output logic        illegal,
   output logic [3:0]  state,
   output logic [31:0] instr_count
);

   typedef enum logic [3:0] {
      FETCH   = 4'd0,
      DECODE  = 4'd1,
      MEMADR  = 4'd2,
      MEMRD   = 4'd3,
      MEMWB   = 4'd4,
      MEMWR   = 4'd5,
      RTEXE   = 4'd6,
      RTWB    = 4'd7,
      BEQ     = 4'd8,
      JUMP    = 4'd9,
      ADDIEXE = 4'd10,
      ADDIWB  = 4'd11
   } state_t;

   localparam logic [5:0] OP_RT   = 6'b000000;
   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_J    = 6'b000010;
   localparam logic [5:0] OP_ADDI = 6'b001000;

   state_t      st_q, st_d;
   logic [5:0]  op_q, fn_q;
   logic [31:0] cnt_q;
   logic        retire;

   function automatic logic fn_ok(input logic [5:0] f);
      return f inside {6'b100000, 6'b100010, 6'b100100,
                       6'b100101, 6'b101010};
   endfunction

   function automatic logic [2:0] fn_alu(input logic [5:0] f);
      logic [2:0] a;
      case (f)
         6'b100000: a = 3'b010;
         6'b100010: a = 3'b110;
         6'b100100: a = 3'b000;
         6'b100101: a = 3'b001;
         6'b101010: a = 3'b111;
         default:   a = 3'b000;
      endcase
      return a;
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= FETCH;
         op_q  <= 6'd0;
         fn_q  <= 6'd0;
         cnt_q <= 32'd0;
      end else begin
         st_q <= st_d;
         if (st_q == DECODE) begin
            op_q <= opcode;
            fn_q <= funct;
         end
         if (retire)
            cnt_q <= cnt_q + 32'd1;
      end
   end

   always_comb begin
      st_d       = FETCH;
      retire     = 1'b0;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = 3'b000;
      reg_write  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      illegal    = 1'b0;
      if (!rst) begin
         case (st_q)
            FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = 2'b01;
               alu_ctrl  = 3'b010;
               ir_write  = mem_ready;
               pc_write  = mem_ready;
               st_d      = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
               alu_src_b = 2'b11;
               alu_ctrl  = 3'b010;
               unique case (1'b1)
                  (opcode == OP_RT) && fn_ok(funct): st_d = RTEXE;
                  (opcode == OP_LW) || (opcode == OP_SW):
                     st_d = MEMADR;
                  opcode == OP_BEQ:  st_d = BEQ;
                  opcode == OP_J:    st_d = JUMP;
                  opcode == OP_ADDI: st_d = ADDIEXE;
                  default:           illegal = 1'b1;
               endcase
            end
            MEMADR: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_ctrl  = 3'b010;
               st_d      = (op_q == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
               mem_req = 1'b1;
               iord    = 1'b1;
               st_d    = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
               reg_write  = 1'b1;
               mem_to_reg = 1'b1;
               retire     = 1'b1;
            end
            MEMWR: begin
               mem_req = 1'b1;
               mem_we  = 1'b1;
               iord    = 1'b1;
               retire  = mem_ready;
               st_d    = mem_ready ? FETCH : MEMWR;
            end
            RTEXE: begin
               alu_src_a = 1'b1;
               alu_ctrl  = fn_alu(fn_q);
               st_d      = RTWB;
            end
            RTWB: begin
               reg_write = 1'b1;
               reg_dst   = 1'b1;
               retire    = 1'b1;
            end
            BEQ: begin
               alu_src_a = 1'b1;
               alu_ctrl  = 3'b110;
               pc_src    = 2'b01;
               pc_write  = zero;
               retire    = 1'b1;
            end
            JUMP: begin
               pc_src   = 2'b10;
               pc_write = 1'b1;
               retire   = 1'b1;
            end
            ADDIEXE: begin
               alu_src_a = 1'b1;
               alu_src_b = 2'b10;
               alu_ctrl  = 3'b010;
               st_d      = ADDIWB;
            end
            ADDIWB: begin
               reg_write = 1'b1;
               retire    = 1'b1;
            end
            default: st_d = FETCH;
         endcase
      end
   end

   assign state       = st_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Scoreboard bench for mips_multicycle_ctrl: per-cycle expected
// state/control/count pushed at drive time, compared at negedge.
module tb_mips_multicycle_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic [5:0]  opcode, funct;
   logic        zero, mem_ready;
   logic        mem_req, mem_we, iord, ir_write, pc_write;
   logic [1:0]  pc_src;
   logic        alu_src_a;
   logic [1:0]  alu_src_b;
   logic [2:0]  alu_ctrl;
   logic        reg_write, reg_dst, mem_to_reg, illegal;
   logic [3:0]  state;
   logic [31:0] instr_count;
   logic [16:0] got_ctl;

   mips_multicycle_ctrl dut (
      .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
      .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src),
      .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_ctrl(alu_ctrl), .reg_write(reg_write),
      .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .illegal(illegal), .state(state), .instr_count(instr_count)
   );

   always #5 clk = ~clk;

   assign got_ctl = {mem_req, mem_we, iord, ir_write, pc_write,
                     pc_src, alu_src_a, alu_src_b, alu_ctrl,
                     reg_write, reg_dst, mem_to_reg, illegal};

   // {req,we,iord,irw,pcw,pcsrc,a,b,alu,rw,rdst,m2r,ill}
   localparam logic [16:0] C_FETCH = 17'b1_0_0_0_0_00_0_01_010_0_0_0_0;
   localparam logic [16:0] C_IRPC  = 17'b0_0_0_1_1_00_0_00_000_0_0_0_0;
   localparam logic [16:0] C_DEC   = 17'b0_0_0_0_0_00_0_11_010_0_0_0_0;
   localparam logic [16:0] C_MADR  = 17'b0_0_0_0_0_00_1_10_010_0_0_0_0;
   localparam logic [16:0] C_MRD   = 17'b1_0_1_0_0_00_0_00_000_0_0_0_0;
   localparam logic [16:0] C_MWB   = 17'b0_0_0_0_0_00_0_00_000_1_0_1_0;
   localparam logic [16:0] C_MWR   = 17'b1_1_1_0_0_00_0_00_000_0_0_0_0;
   localparam logic [16:0] C_RTEXE = 17'b0_0_0_0_0_00_1_00_000_0_0_0_0;
   localparam logic [16:0] C_RTWB  = 17'b0_0_0_0_0_00_0_00_000_1_1_0_0;
   localparam logic [16:0] C_BEQ   = 17'b0_0_0_0_0_01_1_00_110_0_0_0_0;
   localparam logic [16:0] C_PCW   = 17'b0_0_0_0_1_00_0_00_000_0_0_0_0;
   localparam logic [16:0] C_JUMP  = 17'b0_0_0_0_1_10_0_00_000_0_0_0_0;
   localparam logic [16:0] C_AWB   = 17'b0_0_0_0_0_00_0_00_000_1_0_0_0;
   localparam logic [16:0] C_ILL   = 17'd1;
   localparam logic [5:0]  JOP     = 6'h3f;

   typedef struct {
      string       tag;
      logic [3:0]  st;
      logic [16:0] c;
      logic [31:0] n;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_cnt = 32'd0;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   always @(negedge clk) begin
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({e.tag, ".state"}, {28'd0, state}, {28'd0, e.st});
         check({e.tag, ".ctl"}, {15'd0, got_ctl}, {15'd0, e.c});
         check({e.tag, ".count"}, instr_count, e.n);
      end
   end

   task automatic step(input logic rdy, input logic z,
                       input logic [5:0] op, input logic [5:0] fn,
                       input logic [3:0] st, input logic [16:0] c,
                       input string tag);
      exp_t x;
      mem_ready = rdy;
      zero      = z;
      opcode    = op;
      funct     = fn;
      x.tag = tag;
      x.st  = st;
      x.c   = c;
      x.n   = exp_cnt;
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic fetch(input int waits);
      for (int i = 0; i < waits; i++)
         step(1'b0, 1'b0, JOP, 6'd0, 4'd0, C_FETCH, "fetch_wait");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd0, C_FETCH | C_IRPC, "fetch");
   endtask

   task automatic rtype(input logic [5:0] fn, input logic [2:0] ac);
      fetch(0);
      step(1'b1, 1'b0, 6'b000000, fn, 4'd1, C_DEC, "rt_dec");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd6,
           C_RTEXE | {10'd0, ac, 4'd0}, "rt_exe");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd7, C_RTWB, "rt_wb");
      exp_cnt++;
   endtask

   task automatic lw(input int waits);
      fetch(0);
      step(1'b1, 1'b0, 6'b100011, 6'd0, 4'd1, C_DEC, "lw_dec");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd2, C_MADR, "lw_adr");
      for (int i = 0; i < waits; i++)
         step(1'b0, 1'b0, JOP, 6'd0, 4'd3, C_MRD, "lw_wait");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd3, C_MRD, "lw_rd");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd4, C_MWB, "lw_wb");
      exp_cnt++;
   endtask

   task automatic sw0();
      fetch(0);
      step(1'b1, 1'b0, 6'b101011, 6'd0, 4'd1, C_DEC, "sw_dec");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd2, C_MADR, "sw_adr");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd5, C_MWR, "sw_wr");
      exp_cnt++;
   endtask

   task automatic beq(input logic z);
      fetch(0);
      step(1'b1, 1'b0, 6'b000100, 6'd0, 4'd1, C_DEC, "beq_dec");
      step(1'b1, z, JOP, 6'd0, 4'd8, z ? (C_BEQ | C_PCW) : C_BEQ,
           "beq_exe");
      exp_cnt++;
   endtask

   task automatic jmp();
      fetch(0);
      step(1'b1, 1'b0, 6'b000010, 6'd0, 4'd1, C_DEC, "j_dec");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd9, C_JUMP, "j_exe");
      exp_cnt++;
   endtask

   task automatic addi(input int waits);
      fetch(waits);
      step(1'b1, 1'b0, 6'b001000, 6'd0, 4'd1, C_DEC, "addi_dec");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd10, C_MADR, "addi_exe");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd11, C_AWB, "addi_wb");
      exp_cnt++;
   endtask

   task automatic bad(input logic [5:0] op, input logic [5:0] fn);
      fetch(0);
      step(1'b1, 1'b0, op, fn, 4'd1, C_DEC | C_ILL, "ill_dec");
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [5:0] fns [5];
      logic [2:0] acs [5];
      fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
      acs = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111};
      rst = 1'b1;
      mem_ready = 1'b1;
      zero = 1'b0;
      opcode = 6'd0;
      funct = 6'd0;
      @(posedge clk);
      #1;
      step(1'b1, 1'b0, 6'd0, 6'd0, 4'd0, 17'd0, "reset0");
      step(1'b1, 1'b0, 6'd0, 6'd0, 4'd0, 17'd0, "reset1");
      rst = 1'b0;
      for (int i = 0; i < 5; i++)
         rtype(fns[i], acs[i]);
      lw(3);
      beq(1'b1);
      beq(1'b0);
      bad(6'b111111, 6'b100000);
      bad(6'b000000, 6'b000000);
      sw0();
      jmp();
      addi(2);
      lw(0);
      fetch(0);
      step(1'b1, 1'b0, 6'b101011, 6'd0, 4'd1, C_DEC, "swr_dec");
      step(1'b1, 1'b0, JOP, 6'd0, 4'd2, C_MADR, "swr_adr");
      step(1'b0, 1'b0, JOP, 6'd0, 4'd5, C_MWR, "swr_wait0");
      step(1'b0, 1'b0, JOP, 6'd0, 4'd5, C_MWR, "swr_wait1");
      rst = 1'b1;
      step(1'b0, 1'b0, JOP, 6'd0, 4'd5, 17'd0, "swr_rst");
      exp_cnt = 32'd0;
      step(1'b1, 1'b0, JOP, 6'd0, 4'd0, 17'd0, "swr_rst_hold");
      rst = 1'b0;
      addi(0);
      jmp();
      fetch(0);
      check("drain", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
